// File: rtl/pe_pkg.sv
// pe_pkg -- shared definitions for the GF(3^97) processing-element sequencer.
//
// Contents:
//   PE_MUL_CYCLES    default number of PE accumulate cycles per multiply
//                    (99 digits of d0, consumed 3 digits per cycle)
//   PE_CTRL_*        the four 11-bit PE control words, ctrl[10]=c0 ... ctrl[0]=c10
//   ST_IDLE/ST_RUN   sequencer state encoding
//   cnt_width()      width of the RUN cycle counter for a given cycle count
package pe_pkg;

    localparam int PE_MUL_CYCLES = 33;

    // All PE registers hold.
    localparam logic [10:0] PE_CTRL_IDLE      = 11'b00000000000;
    // R1 <= d1, R2 <= d2, R0 <= d0; R3 untouched.
    localparam logic [10:0] PE_CTRL_LOAD      = 11'b11111000000;
    // First accumulate step: old R3 contents are discarded.
    localparam logic [10:0] PE_CTRL_MUL_FIRST = 11'b00000111011;
    // Subsequent accumulate steps: R3 feeds back into the sum.
    localparam logic [10:0] PE_CTRL_MUL_NEXT  = 11'b00000111111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter must hold 0 .. cycles-1; keep at least one bit for the
    // degenerate single-cycle configuration.
    function automatic int cnt_width(input int cycles);
        if (cycles > 1) begin
            return $clog2(cycles);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pe_seq.sv
// pe_seq -- control sequencer for a digit-serial GF(3^97) multiplier PE.
//
// Accepts one operand set per handshake, issues LOAD to the PE, then runs
// MUL_CYCLES accumulate cycles (MUL_FIRST followed by MUL_NEXT) and flags
// the product held in PE register R3 until the consumer takes it. A new
// operand set may be loaded while the previous product is still waiting;
// only the start of the next RUN waits for the result slot to free up.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (aborts any RUN in progress)
//   in_valid   upstream presents operands on PE d0/d1/d2
//   in_ready   operands are accepted this cycle when in_valid is high
//   ctrl       11-bit PE control word (combinational)
//   out_valid  PE R3 holds a completed product
//   out_ready  downstream consumes the product this cycle
//   busy       high while the multiply is running
module pe_seq
    import pe_pkg::*;
#(
    parameter int MUL_CYCLES = PE_MUL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int CNT_W = cnt_width(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_loaded;
    logic             r_out_valid;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_loaded_nxt;
    logic             w_out_valid_nxt;

    logic             w_in_ready;
    logic             w_load;
    logic             w_slot_free;
    logic             w_start;
    logic             w_last;
    logic [10:0]      w_ctrl;

    // Handshake and sequencing conditions shared by the FSM and ctrl decode.
    always_comb begin
        w_in_ready  = !reset && (r_state == ST_IDLE) && !r_loaded;
        w_load      = in_valid && w_in_ready;
        // The result slot is free if empty or being emptied this cycle.
        w_slot_free = !r_out_valid || out_ready;
        // The load cycle itself may launch RUN at its closing edge, so
        // MUL_FIRST immediately follows LOAD when the slot is free.
        w_start     = (r_state == ST_IDLE) && (r_loaded || w_load) && w_slot_free;
        w_last      = (r_state == ST_RUN) && (r_count == CNT_LAST);
    end

    // Next-state logic for state, cycle counter and operands-resident flag.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_loaded_nxt = r_loaded;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_loaded_nxt = 1'b1;
                end else begin
                    w_loaded_nxt = r_loaded;
                end
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                w_count_nxt = CNT_ZERO;
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_count_nxt  = CNT_ZERO;
                    w_loaded_nxt = 1'b0;
                end else begin
                    w_state_nxt  = ST_RUN;
                    w_count_nxt  = r_count + CNT_ONE;
                    w_loaded_nxt = r_loaded;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_count_nxt  = CNT_ZERO;
                w_loaded_nxt = 1'b0;
            end
        endcase
    end

    // Result-slot flag: completion sets it, consumption clears it; a set on
    // the same edge as a consumption wins.
    always_comb begin
        if (w_last) begin
            w_out_valid_nxt = 1'b1;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end else begin
            w_out_valid_nxt = r_out_valid;
        end
    end

    // PE control word decode; reset forces the hold word.
    always_comb begin
        w_ctrl = PE_CTRL_IDLE;
        if (reset) begin
            w_ctrl = PE_CTRL_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        w_ctrl = PE_CTRL_LOAD;
                    end else begin
                        w_ctrl = PE_CTRL_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_count == CNT_ZERO) begin
                        w_ctrl = PE_CTRL_MUL_FIRST;
                    end else begin
                        w_ctrl = PE_CTRL_MUL_NEXT;
                    end
                end
                default: begin
                    w_ctrl = PE_CTRL_IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= CNT_ZERO;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_loaded    <= w_loaded_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign ctrl      = w_ctrl;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_RUN);

endmodule

// File: tb/tb_pe_seq.sv
// tb_pe_seq -- self-checking bench for pe_seq driving a behavioural GF(3^97)
// processing element. The PE model follows the control words the sequencer
// emits (LOAD captures operands, MUL_FIRST/MUL_NEXT perform three Horner
// steps each over the digits of R0), so a wrong control sequence shows up
// as a wrong product. A transaction-level timing model predicts ctrl,
// in_ready, busy and out_valid every cycle.
module tb_pe_seq;

    localparam int MC = 33;
    localparam logic [10:0] C_IDLE  = 11'b00000000000;
    localparam logic [10:0] C_LOAD  = 11'b11111000000;
    localparam logic [10:0] C_FIRST = 11'b00000111011;
    localparam logic [10:0] C_NEXT  = 11'b00000111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [10:0] ctrl;
    logic        out_valid;
    logic        busy;

    logic [197:0] d0 = '0;
    logic [193:0] d1 = '0;
    logic [193:0] exp_prod = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    pe_seq #(.MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- GF(3^97) arithmetic, modulus x^97 + x^12 + 2 --------
    function automatic logic [193:0] gf_add(input logic [193:0] a, input logic [193:0] b);
        logic [193:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 97; i++) begin
            s = int'(a[2*i +: 2]) + int'(b[2*i +: 2]);
            r[2*i +: 2] = 2'(s % 3);
        end
        return r;
    endfunction

    function automatic logic [193:0] gf_scale(input logic [193:0] a, input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return a;
            default: return gf_add(a, a);
        endcase
    endfunction

    // x^97 = -x^12 - 2 = 2x^12 + 1
    function automatic logic [193:0] gf_mulx(input logic [193:0] a);
        logic [193:0] r;
        logic [193:0] p;
        r = {a[191:0], 2'b00};
        p = 194'h2000001;
        return gf_add(r, gf_scale(p, a[193:192]));
    endfunction

    // One PE accumulate cycle: three Horner steps on the top digits of R0.
    function automatic logic [193:0] pe_mul3(input logic [193:0] acc, input logic [197:0] r0,
                                             input logic [193:0] r1);
        logic [193:0] a;
        logic [197:0] b;
        a = acc;
        b = r0;
        for (int j = 0; j < 3; j++) begin
            a = gf_add(gf_mulx(a), gf_scale(r1, b[197:196]));
            b = {b[195:0], 2'b00};
        end
        return a;
    endfunction

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural PE driven by the DUT ctrl ----------------
    logic [197:0] pe_r0 = '0;
    logic [193:0] pe_r1 = '0;
    logic [193:0] pe_r3 = '0;
    int           n_next = 0;

    // ---------------- transaction timing model -----------------------------
    int           m_left = 0;    // RUN cycles still to go
    logic         m_ops  = 1'b0; // operands waiting for RUN
    logic         m_res  = 1'b0; // product waiting for consumer
    logic [193:0] sb[$];         // expected products, oldest first

    logic        e_in_ready;
    logic [10:0] e_ctrl;

    logic        s_reset = 1'b1;
    logic        s_out_ready = 1'b0;
    logic        s_load = 1'b0;
    logic [10:0] s_ctrl = 11'b00000000000;

    // Expected combinational outputs from the model state and live inputs.
    always_comb begin
        e_in_ready = !reset && (m_left == 0) && !m_ops;
        e_ctrl = C_IDLE;
        if (reset) begin
            e_ctrl = C_IDLE;
        end else if (m_left > 0) begin
            e_ctrl = (m_left == MC) ? C_FIRST : C_NEXT;
        end else if (in_valid && e_in_ready) begin
            e_ctrl = C_LOAD;
        end else begin
            e_ctrl = C_IDLE;
        end
    end

    // Compare process: snapshot inputs and check outputs mid-cycle.
    always @(negedge clk) begin
        s_reset     <= reset;
        s_out_ready <= out_ready;
        s_load      <= in_valid && e_in_ready;
        s_ctrl      <= ctrl;
        chk("ctrl", 200'(ctrl), 200'(e_ctrl));
        chk("in_ready", 200'(in_ready), 200'(e_in_ready));
        chk("busy", 200'(busy), 200'(m_left > 0));
        chk("out_valid", 200'(out_valid), 200'(m_res));
        if (out_valid) begin
            chk("sb_nonempty", 200'(sb.size() > 0), 200'(1));
            if (sb.size() > 0) begin
                chk("r3_product", 200'(pe_r3), 200'(sb[0]));
            end
        end
    end

    // Clock-edge update of the timing model and the PE model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_reset) begin
            m_left <= 0;
            m_ops  <= 1'b0;
            m_res  <= 1'b0;
            sb.delete();
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res <= 1'b1;
            end
        end else begin
            if (s_load) begin
                m_ops <= 1'b1;
                sb.push_back(exp_prod);
            end
            if ((m_ops || s_load) && (!m_res || s_out_ready)) begin
                m_left <= MC;
                m_ops  <= 1'b0;
            end
            if (m_res && s_out_ready) begin
                m_res <= 1'b0;
                if (sb.size() > 0) begin
                    void'(sb.pop_front());
                end
            end
        end
        case (s_ctrl)
            C_LOAD: begin
                pe_r0 <= d0;
                pe_r1 <= d1;
            end
            C_FIRST: begin
                pe_r3  <= pe_mul3(194'h0, pe_r0, pe_r1);
                pe_r0  <= {pe_r0[191:0], 6'b000000};
                n_next <= 0;
            end
            C_NEXT: begin
                pe_r3  <= pe_mul3(pe_r3, pe_r0, pe_r1);
                pe_r0  <= {pe_r0[191:0], 6'b000000};
                n_next <= n_next + 1;
            end
            default: begin
                pe_r3 <= pe_r3;
            end
        endcase
    end

    // ---------------- stimulus helpers (start and end at posedge+1) --------
    task automatic do_load(input logic [197:0] a0, input logic [193:0] a1,
                           input logic [193:0] pexp, output int lc);
        int n;
        n = 0;
        d0 = a0;
        d1 = a1;
        exp_prod = pexp;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("load_wait", 200'(in_ready), 200'(1));
        end
        lc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [193:0] pexp, output int oc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_wait", 200'(out_valid), 200'(1));
        end
        oc = cyc;
        chk(name, 200'(pe_r3), 200'(pexp));
        @(posedge clk);
        #1;
    endtask

    logic [193:0] x96;
    logic [193:0] acc;
    int lc, lc2, oc, oc2;

    initial begin
        // Pin the arithmetic model to hand-computed values.
        x96 = 194'h1 << 192;
        chk("model_add", 200'(gf_add(194'h2, 194'h2)), 200'h1);
        chk("model_mulx", 200'(gf_mulx(x96)), 200'h2000001);
        acc = '0;
        for (int i = 0; i < 33; i++) begin
            acc = pe_mul3(acc, 198'h4 << (6 * i), 194'h4);
        end
        chk("model_x_x", 200'(acc), 200'h10);

        // Reset behaviour.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 200'(in_ready), 200'(0));
        chk("rst_ctrl", 200'(ctrl), 200'(C_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 200'(out_valid), 200'(0));
        chk("post_rst_busy", 200'(busy), 200'(0));
        chk("post_rst_in_ready", 200'(in_ready), 200'(1));
        @(posedge clk);
        #1;

        // x * x = x^2, full ctrl sequence and latency.
        out_ready = 1'b1;
        do_load(198'h4, 194'h4, 194'h10, lc);
        wait_out("prod_x_x", 194'h10, oc);
        chk("lat_x_x", 200'(oc - lc), 200'(34));
        chk("n_mul_next", 200'(n_next), 200'(32));

        // 1 * 2 = 2.
        do_load(198'h2, 194'h1, 194'h2, lc);
        wait_out("prod_1_2", 194'h2, oc);
        chk("lat_1_2", 200'(oc - lc), 200'(34));

        // Backpressure: x^96 * x wraps to 2x^12 + 1; second set loads while
        // the first product waits ten cycles.
        out_ready = 1'b0;
        do_load(198'h4, x96, 194'h2000001, lc);
        do_load(198'h6, 194'h5, 194'h12, lc2);
        chk("bp_load_gap", 200'(lc2 - lc), 200'(34));
        @(negedge clk);
        chk("bp_hold_valid", 200'(out_valid), 200'(1));
        chk("bp_hold_prod", 200'(pe_r3), 200'h2000001);
        chk("bp_hold_busy", 200'(busy), 200'(0));
        repeat (9) @(posedge clk);
        #1;
        out_ready = 1'b1;
        oc2 = cyc;
        @(negedge clk);
        chk("bp_still_idle", 200'(busy), 200'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_run_started", 200'(busy), 200'(1));
        @(posedge clk);
        #1;
        wait_out("prod_bp", 194'h12, oc);
        chk("bp_lat", 200'(oc - oc2), 200'(34));

        // Back-to-back with the consumer always ready.
        do_load(198'h4, 194'h4, 194'h10, lc);
        do_load(198'h2, 194'h1, 194'h2, lc2);
        chk("b2b_load_gap", 200'(lc2 - lc), 200'(34));
        wait_out("prod_b2b", 194'h2, oc);
        chk("b2b_lat", 200'(oc - lc2), 200'(34));

        // Reset at RUN count 15 aborts the multiply.
        do_load(198'h4, x96, 194'h2000001, lc);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ctrl", 200'(ctrl), 200'(C_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 200'(busy), 200'(0));
        chk("abort_out_valid", 200'(out_valid), 200'(0));
        chk("abort_in_ready", 200'(in_ready), 200'(1));
        chk("abort_ctrl_after", 200'(ctrl), 200'(C_IDLE));
        @(posedge clk);
        #1;
        do_load(198'h6, 194'h5, 194'h12, lc);
        wait_out("prod_after_abort", 194'h12, oc);
        chk("lat_after_abort", 200'(oc - lc), 200'(34));
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
